serial_subtractor: RTL

- Multi-cycle, bit-serial unsigned/two's-complement subtractor: computes D = A - B - Bin, one bit per clock, LSB first, using a single registered borrow.
- Subtraction counterpart of the combinational ripple-carry adder chain; used where area matters more than latency.
- Start/ready/done handshake; the result is held stable until the next accepted operation.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first.
// Optional signed overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic w_d;
  logic w_br_nxt;
  logic w_last;

  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    unique case (r_state)
      S_IDLE:  ready = 1'b1;
      S_SHIFT: ready = 1'b0;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Results only update on the step that finishes the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      D     <= '0;
      Bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            D    <= {w_d, r_res[WIDTH-1:1]};
            Bout <= w_br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
